variable_table_arbiter: RTL and testbench
=========================================

Name: variable_table_arbiter

Overview:
Shares the single runtime port of the 1-bit-per-variable truth-assignment table between NUM_REQ requesters (clause evaluators, flip unit, initializer).
- Round-robin arbitration; at most one table access per cycle.
- Registered command stage drives the table.
- Read data is routed back to the originating requester with fixed latency.
- hold_i lets the AXI loader freeze runtime access while it owns the table contents.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
VARIABLE_ADDRESS_WIDTH, 11, table address width
REQ_ID_WIDTH, $clog2(NUM_REQ), derived width of internal requester index

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
hold_i  in  1  1 = issue no new grants (AXI side owns table)
req_valid_i  in  NUM_REQ  per-requester request valid
req_ready_o  out  NUM_REQ  per-requester accept, one-hot or zero
req_wr_i  in  NUM_REQ  1 = write, 0 = read
req_addr_i  in  NUM_REQ*VARIABLE_ADDRESS_WIDTH  flattened addresses, requester k at slice k
req_data_i  in  NUM_REQ  write data bit per requester
tbl_en_o  out  1  table runtime enable
tbl_wr_en_o  out  1  table runtime write enable
tbl_addr_o  out  VARIABLE_ADDRESS_WIDTH  table address
tbl_data_o  out  1  table write data
tbl_data_i  in  1  table read data (read-first, registered in table)
rsp_valid_o  out  NUM_REQ  one-hot read-response strobe
rsp_data_o  out  1  read data, valid when any rsp_valid_o bit is set
busy_o  out  1  command or response in flight

Behaviour:
- Reset: all outputs 0, round-robin pointer 0, response pipeline cleared. Reset mid-operation drops in-flight reads; no rsp_valid_o appears after reset.
- Grant, cycle C:
  - If hold_i=0 and any req_valid_i is set, exactly one req_ready_o bit rises.
  - The winner is the first valid index at or above the pointer, wrapping modulo NUM_REQ.
  - req_ready_o is combinational from req_valid_i, pointer and hold_i.
  - Handshake completes at the end of C when valid&ready.
- Pointer update: on grant k, pointer <= (k+1) mod NUM_REQ. No grant leaves the pointer unchanged. Wrap from NUM_REQ-1 goes to 0.
- Command stage:
  - At the end of C, register tbl_en_o=1, tbl_wr_en_o=req_wr_i[k], tbl_addr_o=addr slice k, tbl_data_o=req_data_i[k]; these are visible during C+1.
  - With no grant, tbl_en_o=0 and tbl_wr_en_o=0 next cycle; addr and data hold their last values.
- Response:
  - For a granted read, rsp_valid_o[k]=1 during C+2 only.
  - rsp_data_o = tbl_data_i, passed combinationally through.
  - Writes produce no response.
- Throughput: one access per cycle sustained; back-to-back grants are allowed.
- Ordering: a write granted in C followed by a read of the same address in C+1 returns the new value. A read granted in the same cycle as a write is impossible (single grant).
- hold_i:
  - While hold_i is 1, no new grants are issued.
  - Commands and responses already issued complete normally.
  - busy_o = tbl_en_o | any response stage valid. The AXI loader waits for busy_o=0 before writing.
- Requester obligation: hold req_* stable while valid and not ready. The arbiter does not check this.

Optional Feature:
VAR_ARB_WRITE_PRIORITY_EN
- Defined: if any valid requester has req_wr_i=1, only write requesters compete. Round-robin applies within that subset; the pointer updates as normal. Reads are granted only when no write is pending.
- Undefined: plain round-robin ignoring req_wr_i.

Decomposition:
- Package var_tbl_pkg:
  - VARIABLE_ADDRESS_WIDTH default.
  - NUM_REQ default.
  - Command struct typedef {wr, addr, data, id} for the command stage.
- Sub-module rr_picker:
  - Combinational masked round-robin priority select.
  - Inputs: request vector, pointer. Outputs: one-hot grant, index.
  - Reused by other arbiters.

Test Plan:
- Reset then single read: req_valid_i=0001, req_wr_i=0, addr 0x005, table preloaded 1. Expect req_ready_o=0001 in C, tbl_en_o=1/tbl_wr_en_o=0/tbl_addr_o=0x005 in C+1, rsp_valid_o=0001 with rsp_data_o=1 in C+2.
- Fairness: all four requesters reading continuously. Expect grant order 0,1,2,3,0,... with one grant per cycle, and each rsp_valid_o one-hot arriving exactly 2 cycles after its grant.
- Write-then-read: requester 2 writes addr 0x7FF data 1, requester 3 reads 0x7FF next. Expect rsp_valid_o=1000 with rsp_data_o=1; wrap of pointer 3->0 checked.
- hold_i asserted during a read grant cycle C+1: expect no grant from C+1 onward, the C read response still delivered in C+2, busy_o falling in C+3, grants resuming the cycle hold_i drops.
- Reset pulse in C+1 after a read grant: expect tbl_en_o=0 and no rsp_valid_o in C+2; pointer returns to 0.
- VAR_ARB_WRITE_PRIORITY_EN defined, req 0 read and req 1 write valid with pointer 0. Expect requester 1 granted first, requester 0 granted next cycle. With the macro undefined, requester 0 is granted first.

Source files
------------

// File: rtl/var_tbl_pkg.sv
// var_tbl_pkg: shared definitions for the variable-table runtime arbiter.
//   - default requester count and table address width
//   - command-stage record carried from the grant to the table port
// The command record is sized for the widest supported configuration
// (32-bit address, 16 requesters). Users take only the low bits they need.
package var_tbl_pkg;

    localparam int VAR_TBL_NUM_REQ    = 4;
    localparam int VAR_TBL_ADDR_W     = 11;
    localparam int VAR_TBL_ADDR_W_MAX = 32;
    localparam int VAR_TBL_ID_W_MAX   = 4;

    typedef struct packed {
        logic                          wr;
        logic [VAR_TBL_ADDR_W_MAX-1:0] addr;
        logic                          data;
        logic [VAR_TBL_ID_W_MAX-1:0]   id;
    } var_tbl_cmd_t;

endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational masked round-robin priority select.
//   req_i  : request vector
//   ptr_i  : priority pointer; lowest request at or above it wins,
//            otherwise the search wraps to the lowest request overall
//   gnt_o  : one-hot grant (zero when req_i is zero)
//   idx_o  : index of the granted bit (0 when nothing is granted)
module rr_picker #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o
);

    logic [N-1:0] masked;

    always_comb begin
        masked = '0;
        for (int i = 0; i < N; i++) begin
            masked[i] = req_i[i] && (i >= int'(ptr_i));
        end
    end

    // Scan high to low so the last hit (the lowest index) wins.
    always_comb begin
        idx_o = '0;
        gnt_o = '0;
        if (|masked) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (masked[i]) idx_o = IW'(i);
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (req_i[i]) idx_o = IW'(i);
            end
        end
        if (|req_i) gnt_o = N'(1) << idx_o;
    end

endmodule

// File: rtl/variable_table_arbiter.sv
// variable_table_arbiter: shares the single runtime port of the 1-bit
// truth-assignment table between NUM_REQ requesters.
//   clk_i, rst_i            : clock, synchronous active-high reset
//   hold_i                  : freeze new grants while the AXI loader owns the table
//   req_valid_i/req_ready_o : per-requester handshake (ready one-hot or zero)
//   req_wr_i/addr/data      : per-requester command fields
//   tbl_*_o / tbl_data_i    : registered table command, read-first table data
//   rsp_valid_o/rsp_data_o  : one-hot read response two cycles after grant
//   busy_o                  : command or read response still in flight
// Build option: define VAR_ARB_WRITE_PRIORITY_EN to let pending writes
// pre-empt reads (round-robin among writers only).
module variable_table_arbiter
    import var_tbl_pkg::*;
#(
    parameter int NUM_REQ                = VAR_TBL_NUM_REQ,
    parameter int VARIABLE_ADDRESS_WIDTH = VAR_TBL_ADDR_W,
    parameter int REQ_ID_WIDTH           = $clog2(NUM_REQ)
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic                                      hold_i,
    input  logic [NUM_REQ-1:0]                        req_valid_i,
    output logic [NUM_REQ-1:0]                        req_ready_o,
    input  logic [NUM_REQ-1:0]                        req_wr_i,
    input  logic [NUM_REQ*VARIABLE_ADDRESS_WIDTH-1:0] req_addr_i,
    input  logic [NUM_REQ-1:0]                        req_data_i,
    output logic                                      tbl_en_o,
    output logic                                      tbl_wr_en_o,
    output logic [VARIABLE_ADDRESS_WIDTH-1:0]         tbl_addr_o,
    output logic                                      tbl_data_o,
    input  logic                                      tbl_data_i,
    output logic [NUM_REQ-1:0]                        rsp_valid_o,
    output logic                                      rsp_data_o,
    output logic                                      busy_o
);

    // Stage 1 = command on the table port, stage 2 = read data out of the table.
    localparam int STAGES = 2;

    logic [NUM_REQ-1:0][VARIABLE_ADDRESS_WIDTH-1:0] addr_arr;
    logic [NUM_REQ-1:0]      compete;
    logic [NUM_REQ-1:0]      eligible;
    logic [NUM_REQ-1:0]      gnt;
    logic [REQ_ID_WIDTH-1:0] gnt_idx;
    logic                    grant_any;
    logic                    grant_rd;

    logic [REQ_ID_WIDTH-1:0] ptr_q, ptr_d;
    var_tbl_cmd_t            cmd_q, cmd_d;
    logic                    en_q;
    logic [STAGES:1]         vld_pipe;
    logic [REQ_ID_WIDTH-1:0] rsp_id_q;

    assign addr_arr = req_addr_i;

`ifdef VAR_ARB_WRITE_PRIORITY_EN
    // Any pending write narrows the contest to writers only.
    always_comb begin
        compete = req_valid_i;
        if (|(req_valid_i & req_wr_i)) compete = req_valid_i & req_wr_i;
    end
`else
    assign compete = req_valid_i;
`endif

    // Reset is gated here too so no handshake completes while in reset.
    assign eligible = (rst_i || hold_i) ? '0 : compete;

    rr_picker #(
        .N  (NUM_REQ),
        .IW (REQ_ID_WIDTH)
    ) u_pick (
        .req_i (eligible),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx)
    );

    assign req_ready_o = gnt;
    assign grant_any   = |gnt;
    assign grant_rd    = grant_any && !req_wr_i[gnt_idx];

    always_comb begin
        ptr_d = ptr_q;
        if (grant_any) begin
            ptr_d = (gnt_idx == REQ_ID_WIDTH'(NUM_REQ - 1)) ? '0
                                                             : gnt_idx + REQ_ID_WIDTH'(1);
        end
    end

    // Idle cycles drop the write enable but keep address and data stable.
    always_comb begin
        cmd_d    = cmd_q;
        cmd_d.wr = 1'b0;
        if (grant_any) begin
            cmd_d.wr   = req_wr_i[gnt_idx];
            cmd_d.addr = VAR_TBL_ADDR_W_MAX'(addr_arr[gnt_idx]);
            cmd_d.data = req_data_i[gnt_idx];
            cmd_d.id   = VAR_TBL_ID_W_MAX'(gnt_idx);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q    <= '0;
            cmd_q    <= '0;
            en_q     <= 1'b0;
            vld_pipe <= '0;
            rsp_id_q <= '0;
        end else begin
            ptr_q       <= ptr_d;
            cmd_q       <= cmd_d;
            en_q        <= grant_any;
            vld_pipe[1] <= grant_rd;
            vld_pipe[2] <= vld_pipe[1];
            rsp_id_q    <= cmd_q.id[REQ_ID_WIDTH-1:0];
        end
    end

    assign tbl_en_o    = en_q;
    assign tbl_wr_en_o = cmd_q.wr;
    assign tbl_addr_o  = cmd_q.addr[VARIABLE_ADDRESS_WIDTH-1:0];
    assign tbl_data_o  = cmd_q.data;

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_rsp
        assign rsp_valid_o[k] = vld_pipe[STAGES] && (rsp_id_q == REQ_ID_WIDTH'(k));
    end

    // The table registers its read data, so it already lines up with stage 2.
    assign rsp_data_o = tbl_data_i;
    assign busy_o     = en_q | (|vld_pipe);

    // Upper record bits exist only for wider configurations.
    logic unused_cmd_bits;
    assign unused_cmd_bits = ^{cmd_q.addr, cmd_q.id};

endmodule

// File: tb/tb_variable_table_arbiter.sv
// Directed bench for variable_table_arbiter with a behavioural read-first
// registered table (2048 x 1) attached to the runtime port.
module tb_variable_table_arbiter;

    localparam int NR = 4;
    localparam int AW = 11;
    localparam logic [2047:0] MEM_INIT = (2048'(1) << 5) | (2048'(1) << 17) | (2048'(1) << 19);

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           hold = 1'b0;
    logic [NR-1:0]  req_valid = '0;
    logic [NR-1:0]  req_ready;
    logic [NR-1:0]  req_wr = '0;
    logic [NR*AW-1:0] req_addr = '0;
    logic [NR-1:0]  req_data = '0;
    logic           tbl_en, tbl_wr_en, tbl_data_o, tbl_q;
    logic [AW-1:0]  tbl_addr;
    logic [NR-1:0]  rsp_valid;
    logic           rsp_data;
    logic           busy;
    logic [2047:0]  mem;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    variable_table_arbiter #(.NUM_REQ(NR), .VARIABLE_ADDRESS_WIDTH(AW)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .hold_i      (hold),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_wr_i    (req_wr),
        .req_addr_i  (req_addr),
        .req_data_i  (req_data),
        .tbl_en_o    (tbl_en),
        .tbl_wr_en_o (tbl_wr_en),
        .tbl_addr_o  (tbl_addr),
        .tbl_data_o  (tbl_data_o),
        .tbl_data_i  (tbl_q),
        .rsp_valid_o (rsp_valid),
        .rsp_data_o  (rsp_data),
        .busy_o      (busy)
    );

    // Table model: read-first, registered read data.
    always @(posedge clk) begin
        if (rst) begin
            mem   <= MEM_INIT;
            tbl_q <= 1'b0;
        end else if (tbl_en) begin
            tbl_q <= mem[tbl_addr];
            if (tbl_wr_en) mem[tbl_addr] <= tbl_data_o;
        end
    end

    task automatic set_addr(input int k, input logic [AW-1:0] a);
        req_addr[k*AW +: AW] = a;
    endtask

    task automatic do_reset;
        @(negedge clk); rst = 1'b1; req_valid = '0; hold = 1'b0;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        req_valid = '1; #1;
        vectors++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_ready got=%b exp=0000", req_ready); end
        @(negedge clk); rst = 1'b0; req_valid = '0; #1;
        vectors++; if (tbl_en !== 1'b0) begin errors++; $display("FAIL rst_tbl_en got=%b exp=0", tbl_en); end
        vectors++; if (tbl_wr_en !== 1'b0) begin errors++; $display("FAIL rst_tbl_wr_en got=%b exp=0", tbl_wr_en); end
        vectors++; if (tbl_addr !== 11'h000) begin errors++; $display("FAIL rst_tbl_addr got=%h exp=000", tbl_addr); end
        vectors++; if (tbl_data_o !== 1'b0) begin errors++; $display("FAIL rst_tbl_data got=%b exp=0", tbl_data_o); end
        vectors++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL rst_rsp_valid got=%b exp=0000", rsp_valid); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
    endtask

    task automatic test_single_read;
        @(negedge clk); req_valid = 4'b0001; req_wr = '0; set_addr(0, 11'h005); #1;
        vectors++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL sr_ready got=%b exp=0001", req_ready); end
        @(negedge clk); req_valid = '0; #1;
        vectors++; if (tbl_en !== 1'b1) begin errors++; $display("FAIL sr_tbl_en got=%b exp=1", tbl_en); end
        vectors++; if (tbl_wr_en !== 1'b0) begin errors++; $display("FAIL sr_tbl_wr_en got=%b exp=0", tbl_wr_en); end
        vectors++; if (tbl_addr !== 11'h005) begin errors++; $display("FAIL sr_tbl_addr got=%h exp=005", tbl_addr); end
        vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL sr_busy got=%b exp=1", busy); end
        vectors++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL sr_rsp_early got=%b exp=0000", rsp_valid); end
        @(negedge clk); #1;
        vectors++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL sr_rsp_valid got=%b exp=0001", rsp_valid); end
        vectors++; if (rsp_data !== 1'b1) begin errors++; $display("FAIL sr_rsp_data got=%b exp=1", rsp_data); end
        vectors++; if (tbl_en !== 1'b0) begin errors++; $display("FAIL sr_tbl_idle got=%b exp=0", tbl_en); end
    endtask

    task automatic test_fairness;
        logic [NR-1:0] exp_v;
        logic          exp_d;
        do_reset();
        for (int k = 0; k < NR; k++) set_addr(k, AW'(16 + k));
        req_wr = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); req_valid = (i < 8) ? 4'b1111 : 4'b0000; #1;
            if (i < 8) begin
                exp_v = 4'(1 << (i % 4));
                vectors++; if (req_ready !== exp_v) begin errors++; $display("FAIL fair_ready[%0d] got=%b exp=%b", i, req_ready, exp_v); end
            end
            exp_v = (i >= 2) ? 4'(1 << ((i - 2) % 4)) : 4'b0000;
            vectors++; if (rsp_valid !== exp_v) begin errors++; $display("FAIL fair_rsp[%0d] got=%b exp=%b", i, rsp_valid, exp_v); end
            if (i >= 2) begin
                exp_d = (((i - 2) % 4) % 2) == 1;
                vectors++; if (rsp_data !== exp_d) begin errors++; $display("FAIL fair_data[%0d] got=%b exp=%b", i, rsp_data, exp_d); end
            end
        end
    endtask

    task automatic test_write_then_read;
        // pointer is 0 here: lone requester 2 wins, then 3, then wrap to 0
        @(negedge clk); req_valid = 4'b0100; req_wr = 4'b0100; req_data = 4'b0100; set_addr(2, 11'h7FF); #1;
        vectors++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL wr_ready got=%b exp=0100", req_ready); end
        @(negedge clk); req_valid = 4'b1000; req_wr = '0; req_data = '0; set_addr(3, 11'h7FF); #1;
        vectors++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL rd3_ready got=%b exp=1000", req_ready); end
        vectors++; if (tbl_en !== 1'b1) begin errors++; $display("FAIL wr_tbl_en got=%b exp=1", tbl_en); end
        vectors++; if (tbl_wr_en !== 1'b1) begin errors++; $display("FAIL wr_tbl_wr_en got=%b exp=1", tbl_wr_en); end
        vectors++; if (tbl_addr !== 11'h7FF) begin errors++; $display("FAIL wr_tbl_addr got=%h exp=7ff", tbl_addr); end
        vectors++; if (tbl_data_o !== 1'b1) begin errors++; $display("FAIL wr_tbl_data got=%b exp=1", tbl_data_o); end
        @(negedge clk); req_valid = 4'b1001; set_addr(0, 11'h005); #1;
        vectors++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL wrap_ready got=%b exp=0001", req_ready); end
        vectors++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL wr_no_rsp got=%b exp=0000", rsp_valid); end
        vectors++; if (tbl_wr_en !== 1'b0) begin errors++; $display("FAIL rd3_wr_en got=%b exp=0", tbl_wr_en); end
        @(negedge clk); req_valid = '0; #1;
        vectors++; if (rsp_valid !== 4'b1000) begin errors++; $display("FAIL rd3_rsp got=%b exp=1000", rsp_valid); end
        vectors++; if (rsp_data !== 1'b1) begin errors++; $display("FAIL rd3_data got=%b exp=1", rsp_data); end
        @(negedge clk); #1;
        vectors++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL rd0_rsp got=%b exp=0001", rsp_valid); end
    endtask

    task automatic test_hold;
        // pointer is 1 here
        for (int k = 0; k < NR; k++) set_addr(k, AW'(16 + k));
        req_wr = '0;
        @(negedge clk); req_valid = 4'b0010; #1;
        vectors++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL hold_c_ready got=%b exp=0010", req_ready); end
        @(negedge clk); hold = 1'b1; req_valid = 4'b1111; #1;
        vectors++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL hold_c1_ready got=%b exp=0000", req_ready); end
        vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL hold_c1_busy got=%b exp=1", busy); end
        @(negedge clk); #1;
        vectors++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL hold_c2_ready got=%b exp=0000", req_ready); end
        vectors++; if (rsp_valid !== 4'b0010) begin errors++; $display("FAIL hold_c2_rsp got=%b exp=0010", rsp_valid); end
        vectors++; if (rsp_data !== 1'b1) begin errors++; $display("FAIL hold_c2_data got=%b exp=1", rsp_data); end
        vectors++; if (tbl_en !== 1'b0) begin errors++; $display("FAIL hold_c2_tbl_en got=%b exp=0", tbl_en); end
        vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL hold_c2_busy got=%b exp=1", busy); end
        @(negedge clk); #1;
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_c3_busy got=%b exp=0", busy); end
        vectors++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL hold_c3_rsp got=%b exp=0000", rsp_valid); end
        @(negedge clk); hold = 1'b0; #1;
        vectors++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL hold_resume got=%b exp=0100", req_ready); end
        @(negedge clk); req_valid = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        // pointer is 3 here
        set_addr(0, 11'h005); req_wr = '0;
        @(negedge clk); req_valid = 4'b0001; #1;
        vectors++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rm_ready got=%b exp=0001", req_ready); end
        @(negedge clk); req_valid = '0; rst = 1'b1;
        @(negedge clk); rst = 1'b0; req_valid = 4'b1111; #1;
        vectors++; if (tbl_en !== 1'b0) begin errors++; $display("FAIL rm_tbl_en got=%b exp=0", tbl_en); end
        vectors++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL rm_rsp got=%b exp=0000", rsp_valid); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy got=%b exp=0", busy); end
        vectors++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rm_ptr0 got=%b exp=0001", req_ready); end
        @(negedge clk); req_valid = '0; #1;
        vectors++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL rm_rsp_late got=%b exp=0000", rsp_valid); end
        @(negedge clk); #1;
        vectors++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL rm_new_rsp got=%b exp=0001", rsp_valid); end
    endtask

    task automatic test_write_priority;
        logic [NR-1:0] first;
        logic          first_wr;
`ifdef VAR_ARB_WRITE_PRIORITY_EN
        first = 4'b0010; first_wr = 1'b1;
`else
        first = 4'b0001; first_wr = 1'b0;
`endif
        do_reset();
        set_addr(0, 11'h005); set_addr(1, 11'h020); req_wr = 4'b0010; req_data = 4'b0010;
        @(negedge clk); req_valid = 4'b0011; #1;
        vectors++; if (req_ready !== first) begin errors++; $display("FAIL wp_first got=%b exp=%b", req_ready, first); end
        @(negedge clk); req_valid = 4'b0011 & ~first; #1;
        vectors++; if (req_ready !== (4'b0011 & ~first)) begin errors++; $display("FAIL wp_second got=%b exp=%b", req_ready, 4'b0011 & ~first); end
        vectors++; if (tbl_wr_en !== first_wr) begin errors++; $display("FAIL wp_wr_en got=%b exp=%b", tbl_wr_en, first_wr); end
        @(negedge clk); req_valid = '0; req_wr = '0; req_data = '0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_fairness();
        test_write_then_read();
        test_hold();
        test_reset_mid();
        test_write_priority();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
